// File: rtl/add_select_pkg.sv
// Shared types for the conditional-adder select scheduler: default sizes, index width helper,
// scheduler state and the {sel0, sel1, dwell} profile record.
package add_select_pkg;

    localparam int unsigned ADD_SEL_N_INPUTS   = 8;
    localparam int unsigned ADD_SEL_N_PROFILES = 4;
    localparam int unsigned ADD_SEL_DWELL_W    = 16;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StPending,
        StRun
    } sched_state_e;

    typedef struct packed {
        logic [ADD_SEL_N_INPUTS-1:0] sel0;
        logic [ADD_SEL_N_INPUTS-1:0] sel1;
        logic [ADD_SEL_DWELL_W-1:0]  dwell;
    } profile_t;

endpackage

// File: rtl/add_select_dwell_timer.sv
// Dwell counter for profile sequencing: load wins over decrement, counts down to zero and stops,
// and flags expiry on the tick that consumes the last remaining count.
module add_select_dwell_timer
    import add_select_pkg::*;
#(
    parameter int unsigned DWELL_W = ADD_SEL_DWELL_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic               expire_o
);

    logic [DWELL_W-1:0] cnt_q;

    assign expire_o = dec_i && (cnt_q == DWELL_W'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - DWELL_W'(1);
        end
    end

endmodule

// File: rtl/add_select_scheduler.sv
// Shadow/active mask-profile scheduler for the conditional adder; masks only change on ticks.
// Define ADD_SELECT_SEQUENCER_EN for multi-profile dwell sequencing, else a single profile is held.
module add_select_scheduler
    import add_select_pkg::*;
#(
    parameter int unsigned N_INPUTS   = ADD_SEL_N_INPUTS,
    parameter int unsigned N_PROFILES = ADD_SEL_N_PROFILES,
    parameter int unsigned DWELL_W    = ADD_SEL_DWELL_W,
    localparam int unsigned IDX_W     = idx_w(N_PROFILES),
    localparam int unsigned CNT_W     = IDX_W + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [IDX_W-1:0]    cfg_idx_i,
    input  logic [N_INPUTS-1:0] cfg_sel0_i,
    input  logic [N_INPUTS-1:0] cfg_sel1_i,
    input  logic [DWELL_W-1:0]  cfg_dwell_i,
    input  logic [CNT_W-1:0]    cfg_count_i,
    input  logic                commit_i,
    input  logic                tick_i,
    output logic [N_INPUTS-1:0] add_select0_o,
    output logic [N_INPUTS-1:0] add_select1_o,
    output logic [IDX_W-1:0]    active_idx_o,
    output logic                pending_o,
    output logic                switch_o
);

`ifdef ADD_SELECT_SEQUENCER_EN
    localparam int unsigned N_ENTRIES = N_PROFILES;
`else
    localparam int unsigned N_ENTRIES = 1;
`endif

    sched_state_e state_q;
    profile_t     shadow_q [N_ENTRIES];
    profile_t     active_q [N_ENTRIES];
    profile_t     wr_entry;
    logic         switch_q;
    logic         cfg_we;
    logic         do_xfer;

    // Shadow is frozen while a commit waits, so the tick copies exactly what was committed.
    assign cfg_ready_o = rst_ni && (state_q != StPending) && !commit_i;
    assign cfg_we      = cfg_valid_i && cfg_ready_o;
    assign do_xfer     = tick_i && ((state_q == StPending) || commit_i);
    assign pending_o   = (state_q == StPending);
    assign switch_o    = switch_q;

`ifdef ADD_SELECT_SEQUENCER_EN
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    next_idx;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_clamped;
    logic [CNT_W-1:0]    idx_inc;
    logic [N_INPUTS-1:0] sel0_q;
    logic [N_INPUTS-1:0] sel1_q;
    logic                expire;
    logic                advance;
    logic                timer_load;
    logic                timer_dec;
    logic [DWELL_W-1:0]  timer_val;

    assign wr_entry = '{sel0: cfg_sel0_i, sel1: cfg_sel1_i, dwell: cfg_dwell_i};

    always_comb begin
        count_clamped = cfg_count_i;
        if (cfg_count_i == '0) begin
            count_clamped = CNT_W'(1);
        end else if (cfg_count_i > CNT_W'(N_PROFILES)) begin
            count_clamped = CNT_W'(N_PROFILES);
        end
        idx_inc  = {1'b0, idx_q} + CNT_W'(1);
        next_idx = (idx_inc == count_q) ? '0 : idx_inc[IDX_W-1:0];
    end

    // A one-profile sequence never switches, even when its dwell runs out.
    assign advance    = (state_q == StRun) && tick_i && !do_xfer && expire && (count_q > CNT_W'(1));
    assign timer_load = do_xfer || advance;
    assign timer_dec  = tick_i && (state_q == StRun);
    assign timer_val  = do_xfer ? shadow_q[0].dwell : active_q[next_idx].dwell;

    add_select_dwell_timer #(
        .DWELL_W(DWELL_W)
    ) u_dwell_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (timer_load),
        .load_val_i(timer_val),
        .dec_i     (timer_dec),
        .expire_o  (expire)
    );

    assign add_select0_o = sel0_q;
    assign add_select1_o = sel1_q;
    assign active_idx_o  = idx_q;
`else
    logic unused_cfg;

    assign wr_entry      = '{sel0: cfg_sel0_i, sel1: cfg_sel1_i, dwell: '0};
    assign unused_cfg    = ^{cfg_idx_i, cfg_dwell_i, cfg_count_i, active_q[0].dwell};
    assign add_select0_o = active_q[0].sel0;
    assign add_select1_o = active_q[0].sel1;
    assign active_idx_o  = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            switch_q <= 1'b0;
            for (int i = 0; i < int'(N_ENTRIES); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
`ifdef ADD_SELECT_SEQUENCER_EN
            idx_q   <= '0;
            count_q <= CNT_W'(1);
            sel0_q  <= '0;
            sel1_q  <= '0;
`endif
        end else begin
            switch_q <= 1'b0;
`ifdef ADD_SELECT_SEQUENCER_EN
            if (cfg_we) shadow_q[cfg_idx_i] <= wr_entry;
`else
            if (cfg_we) shadow_q[0] <= wr_entry;
`endif
            if (do_xfer) begin
                state_q  <= StRun;
                active_q <= shadow_q;
                switch_q <= 1'b1;
`ifdef ADD_SELECT_SEQUENCER_EN
                idx_q   <= '0;
                count_q <= count_clamped;
                sel0_q  <= shadow_q[0].sel0;
                sel1_q  <= shadow_q[0].sel1;
`endif
            end else if (commit_i && (state_q != StPending)) begin
                state_q <= StPending;
            end
`ifdef ADD_SELECT_SEQUENCER_EN
            else if (advance) begin
                idx_q    <= next_idx;
                sel0_q   <= active_q[next_idx].sel0;
                sel1_q   <= active_q[next_idx].sel1;
                switch_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: doc/add_select_scheduler.md
ADD_SELECT_SCHEDULER -- requirements
Module: add_select_scheduler

Interface
REQ-001 Parameters SHALL be: N_INPUTS, 8, adder input count (mask width); N_PROFILES, 4, mask profiles held; DWELL_W, 16, dwell counter width.
REQ-002 clk_i  in  1  clock; all logic SHALL be on its rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 cfg_valid_i  in  1  profile write request.
REQ-005 cfg_ready_o  out  1  profile write accepted when high with cfg_valid_i.
REQ-006 cfg_idx_i  in  clog2(N_PROFILES)  shadow profile index to write.
REQ-007 cfg_sel0_i / cfg_sel1_i  in  N_INPUTS each  select masks for adder outputs 0 and 1.
REQ-008 cfg_dwell_i  in  DWELL_W  profile dwell in ticks; 0 = hold indefinitely.
REQ-009 cfg_count_i  in  clog2(N_PROFILES)+1  number of profiles in sequence, sampled at commit.
REQ-010 commit_i  in  1  single-cycle pulse: request shadow-to-active transfer.
REQ-011 tick_i  in  1  sample-rate strobe; all mask changes SHALL occur only on ticks.
REQ-012 add_select0_o / add_select1_o  out  N_INPUTS each  registered masks to the conditional adder.
REQ-013 active_idx_o  out  clog2(N_PROFILES)  index of profile currently driven.
REQ-014 pending_o  out  1  commit waiting for tick.
REQ-015 switch_o  out  1  one-cycle pulse in the cycle masks change.

Function
REQ-016 Shadow table SHALL store N_PROFILES entries {sel0, sel1, dwell}; active table SHALL be a separate copy; outputs SHALL come only from active table.
REQ-017 Write handshake: entry cfg_idx_i SHALL be written on an edge where cfg_valid_i && cfg_ready_o; cfg_ready_o = (state != PENDING) && !commit_i.
REQ-018 States SHALL be IDLE, PENDING, RUN.
REQ-019 IDLE/RUN + commit_i without tick_i -> PENDING; pending_o=1.
REQ-020 commit_i with tick_i same cycle (any state but PENDING) SHALL transfer on that edge, no PENDING.
REQ-021 PENDING + tick_i -> copy full shadow to active, latch cfg_count_i (0 treated as 1, >N_PROFILES clamped to N_PROFILES), index=0, load dwell of profile 0, -> RUN, switch_o=1 next cycle.
REQ-022 commit_i while PENDING SHALL be ignored.
REQ-023 Mask outputs SHALL update on the edge after the transfer/advance tick is sampled (latency 1 clock from tick).
REQ-024 RUN: dwell counter SHALL decrement on each tick_i; tick with counter==1 SHALL advance index (wrap count-1 -> 0), reload next dwell, pulse switch_o.
REQ-025 Dwell 0 SHALL never advance; cfg_count 1 SHALL hold profile 0 regardless of dwell.
REQ-026 Shadow writes during RUN SHALL NOT affect outputs until next commit.
REQ-027 Dwell counter SHALL saturate-free decrement only when nonzero; no wrap below zero.

Reset
REQ-028 On rst_ni low: state IDLE, both tables zero, masks 0, active_idx_o 0, pending_o 0, switch_o 0, counter 0, count 1.
REQ-029 Reset mid-PENDING or mid-RUN SHALL discard pending commit and table contents immediately (asynchronous).
REQ-030 cfg_ready_o SHALL be 0 during reset, 1 in the first cycle after release.

Configuration
REQ-031 Macro ADD_SELECT_SEQUENCER_EN defined: full multi-profile sequencing per REQ-024..025.
REQ-032 Macro undefined: single profile only; cfg_idx_i, cfg_dwell_i, cfg_count_i ignored; no dwell counter; active_idx_o tied 0; RUN holds profile 0 until next commit.

Structure
REQ-033 Package add_select_pkg SHALL hold N_INPUTS default, index width function, state enum, profile struct {sel0, sel1, dwell}.
REQ-034 Sub-module add_select_dwell_timer SHALL implement load/decrement/expire counter; instantiated only under ADD_SELECT_SEQUENCER_EN.

Verification
REQ-035 Reset, write idx0 sel0=0x03 sel1=0x80, commit, tick 5 cycles later -> masks 0x03/0x80 one clock after tick, switch_o one pulse, pending_o high 5 cycles.
REQ-036 Profiles 0..2 dwell 2/3/1, count 3, commit+tick same cycle -> index sequence 0,0,1,1,1,2,0 on successive ticks.
REQ-037 Commit, then cfg_valid_i while PENDING -> cfg_ready_o 0, no write; second commit ignored; single transfer on tick.
REQ-038 RUN with profile 0 dwell 0, rewrite shadow 0 = 0xFF -> outputs unchanged over 100 ticks until commit+tick.
REQ-039 Assert rst_ni low mid-RUN -> masks 0 same cycle, state IDLE, pending_o 0 after release.
REQ-040 Build without ADD_SELECT_SEQUENCER_EN, write idx2 dwell 1, commit, 10 ticks -> active_idx_o 0, masks from write, no further switch_o.
